// File: rtl/gcn_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// gcn_pkg
// Shared types and constants for the GCN layer-pass phase scheduler.
//   sched_state_t : top-level sequencer states
//   REQ_TRANS     : requester index of the transformation controller
//   REQ_AGGR      : requester index of the aggregation controller
//   N_REQ         : number of read requesters sharing the input memory
// -----------------------------------------------------------------------------
package gcn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } sched_state_t;

  localparam int REQ_TRANS = 0;
  localparam int REQ_AGGR  = 1;
  localparam int N_REQ     = 2;

endpackage

// File: rtl/rr_arbiter2.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter with a per-requester mask and a last-grant
// register. Grants are combinational (same cycle as the request) and one-hot.
// When both requesters are eligible the one not granted last wins; the
// last-grant register only moves when a grant is issued.
//
// Ports:
//   clk      in   clock
//   reset_n  in   asynchronous active-low reset (transformation preferred)
//   i_en     in   arbitration enable; no grants when low
//   i_req    in   [N_REQ] request vector, indexed by REQ_TRANS / REQ_AGGR
//   i_mask   in   [N_REQ] requesters whose request must be ignored
//   o_gnt    out  [N_REQ] one-hot combinational grant
// -----------------------------------------------------------------------------
module rr_arbiter2
  import gcn_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_en,
  input  logic [N_REQ-1:0] i_req,
  input  logic [N_REQ-1:0] i_mask,
  output logic [N_REQ-1:0] o_gnt
);

  // High when the most recent grant went to the transformation requester,
  // which hands priority to aggregation on the next tie.
  logic             r_last_was_trans;
  logic [N_REQ-1:0] w_elig;

  assign w_elig = i_req & ~i_mask & {N_REQ{i_en}};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    o_gnt = '0;
    if (w_elig[REQ_TRANS] && w_elig[REQ_AGGR]) begin
      if (r_last_was_trans) begin
        o_gnt[REQ_AGGR] = 1'b1;
      end else begin
        o_gnt[REQ_TRANS] = 1'b1;
      end
    end else begin
      o_gnt = w_elig;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the reset branch is asynchronous and active-low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_was_trans <= 1'b0;
    end else if (|o_gnt) begin
      r_last_was_trans <= o_gnt[REQ_TRANS];
    end
  end

endmodule

// File: rtl/gcn_phase_scheduler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// gcn_phase_scheduler
// Top-level sequencer for one GCN layer pass. Launches the transformation
// (feature x weight) and aggregation (adjacency x product) controllers
// together, arbitrates their shared single-port input-memory read channel
// round-robin while the pass runs, returns read-data-valid to the winner one
// cycle after its grant, and reports busy/done to the host.
//
// Optional build macro: GCN_SCHED_PERF_CNT_EN adds per-phase cycle counters
// trans_cycles / aggr_cycles.
//
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   start                      host launch request, sampled in IDLE/DONE
//   trans_start, aggr_start    one-cycle launch pulses (LAUNCH state)
//   trans_done, aggr_done      phase completion, level or pulse
//   req_*/addr_*               read requests held until granted, addresses
//   gnt_trans, gnt_aggr        combinational one-hot grants (RUN only)
//   mem_read_en, mem_addr      shared memory read port (addr 0 when idle)
//   rvalid_trans, rvalid_aggr  registered grant = read data valid
//   busy, done                 host status
//   trans_cycles, aggr_cycles  RUN cycles until each phase finished
//                              (GCN_SCHED_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module gcn_phase_scheduler
  import gcn_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int CYC_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              trans_start,
  input  logic              trans_done,
  output logic              aggr_start,
  input  logic              aggr_done,
  input  logic              req_trans,
  input  logic [ADDR_W-1:0] addr_trans,
  input  logic              req_aggr,
  input  logic [ADDR_W-1:0] addr_aggr,
  output logic              gnt_trans,
  output logic              gnt_aggr,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              rvalid_trans,
  output logic              rvalid_aggr,
  output logic              busy,
  output logic              done
`ifdef GCN_SCHED_PERF_CNT_EN
  ,
  output logic [CYC_W-1:0]  trans_cycles,
  output logic [CYC_W-1:0]  aggr_cycles
`endif
);

  sched_state_t     r_state;
  sched_state_t     w_state_nxt;
  logic             r_trans_seen;
  logic             r_aggr_seen;
  logic             r_rvalid_trans;
  logic             r_rvalid_aggr;
  logic             w_run;
  logic             w_launch;
  logic             w_both_fin;
  logic [N_REQ-1:0] w_req;
  logic [N_REQ-1:0] w_mask;
  logic [N_REQ-1:0] w_gnt;

  assign w_run    = (r_state == RUN);
  assign w_launch = (r_state == LAUNCH);

  // A done seen this very cycle counts, so simultaneous or staggered dones
  // both reach DONE on the following edge.
  assign w_both_fin = (r_trans_seen | trans_done) & (r_aggr_seen | aggr_done);

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_nxt = LAUNCH;
      LAUNCH:  w_state_nxt = RUN;
      RUN:     if (w_both_fin) w_state_nxt = DONE;
      DONE:    if (start) w_state_nxt = LAUNCH;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign trans_start = w_launch;
  assign aggr_start  = w_launch;
  assign busy        = w_launch | w_run;
  assign done        = (r_state == DONE);

  // Sticky completion flags: cleared on every launch, set by a done in RUN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_trans_seen <= 1'b0;
      r_aggr_seen  <= 1'b0;
    end else if (w_launch) begin
      r_trans_seen <= 1'b0;
      r_aggr_seen  <= 1'b0;
    end else if (w_run) begin
      if (trans_done) r_trans_seen <= 1'b1;
      if (aggr_done)  r_aggr_seen  <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Shared read channel
  // ---------------------------------------------------------------------------
  assign w_req[REQ_TRANS]  = req_trans;
  assign w_req[REQ_AGGR]   = req_aggr;
  // A finished phase may leave its request line high; it must not win slots.
  assign w_mask[REQ_TRANS] = r_trans_seen;
  assign w_mask[REQ_AGGR]  = r_aggr_seen;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .i_en    (w_run),
    .i_req   (w_req),
    .i_mask  (w_mask),
    .o_gnt   (w_gnt)
  );

  assign gnt_trans   = w_gnt[REQ_TRANS];
  assign gnt_aggr    = w_gnt[REQ_AGGR];
  assign mem_read_en = |w_gnt;

  always_comb begin
    mem_addr = '0;
    if (gnt_trans) begin
      mem_addr = addr_trans;
    end else if (gnt_aggr) begin
      mem_addr = addr_aggr;
    end
  end

  // Memory has one cycle of read latency: data valid is the delayed grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rvalid_trans <= 1'b0;
      r_rvalid_aggr  <= 1'b0;
    end else begin
      r_rvalid_trans <= gnt_trans;
      r_rvalid_aggr  <= gnt_aggr;
    end
  end

  assign rvalid_trans = r_rvalid_trans;
  assign rvalid_aggr  = r_rvalid_aggr;

  // ---------------------------------------------------------------------------
  // Optional per-phase cycle counters
  // ---------------------------------------------------------------------------
`ifdef GCN_SCHED_PERF_CNT_EN
  localparam logic [CYC_W-1:0] CYC_MAX = '1;

  logic [CYC_W-1:0] r_trans_cyc;
  logic [CYC_W-1:0] r_aggr_cyc;

  // Each counter runs while its phase is unfinished and saturates; the value
  // holds through DONE so the host can read it until the next launch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_trans_cyc <= '0;
      r_aggr_cyc  <= '0;
    end else if (w_launch) begin
      r_trans_cyc <= '0;
      r_aggr_cyc  <= '0;
    end else if (w_run) begin
      if (!r_trans_seen && (r_trans_cyc != CYC_MAX)) begin
        r_trans_cyc <= r_trans_cyc + CYC_W'(1);
      end
      if (!r_aggr_seen && (r_aggr_cyc != CYC_MAX)) begin
        r_aggr_cyc <= r_aggr_cyc + CYC_W'(1);
      end
    end
  end

  assign trans_cycles = r_trans_cyc;
  assign aggr_cycles  = r_aggr_cyc;
`else
  logic [CYC_W-1:0] w_unused_cyc;
  assign w_unused_cyc = '0;
`endif

endmodule

// File: tb/tb_gcn_phase_scheduler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_gcn_phase_scheduler
// Self-checking bench for gcn_phase_scheduler. A behavioural model tracks the
// pass phase, the sticky completion flags, the round-robin preference and the
// one-cycle read latency, and predicts every output each cycle. Inputs change
// on the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_gcn_phase_scheduler;

  localparam int ADDR_W  = 7;
  localparam int CYC_W   = 16;
  localparam int OBS_W   = ADDR_W + 9;
  localparam int CYC_MAX = (1 << CYC_W) - 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic              trans_start;
  logic              trans_done;
  logic              aggr_start;
  logic              aggr_done;
  logic              req_trans;
  logic [ADDR_W-1:0] addr_trans;
  logic              req_aggr;
  logic [ADDR_W-1:0] addr_aggr;
  logic              gnt_trans;
  logic              gnt_aggr;
  logic              mem_read_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              rvalid_trans;
  logic              rvalid_aggr;
  logic              busy;
  logic              done;
`ifdef GCN_SCHED_PERF_CNT_EN
  logic [CYC_W-1:0]  trans_cycles;
  logic [CYC_W-1:0]  aggr_cycles;
`endif

  gcn_phase_scheduler #(.ADDR_W(ADDR_W), .CYC_W(CYC_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .trans_start  (trans_start),
    .trans_done   (trans_done),
    .aggr_start   (aggr_start),
    .aggr_done    (aggr_done),
    .req_trans    (req_trans),
    .addr_trans   (addr_trans),
    .req_aggr     (req_aggr),
    .addr_aggr    (addr_aggr),
    .gnt_trans    (gnt_trans),
    .gnt_aggr     (gnt_aggr),
    .mem_read_en  (mem_read_en),
    .mem_addr     (mem_addr),
    .rvalid_trans (rvalid_trans),
    .rvalid_aggr  (rvalid_aggr),
    .busy         (busy),
    .done         (done)
`ifdef GCN_SCHED_PERF_CNT_EN
    ,
    .trans_cycles (trans_cycles),
    .aggr_cycles  (aggr_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef enum int {P_IDLE, P_LAUNCH, P_RUN, P_DONE} phase_e;

  phase_e            m_phase;
  bit                m_t_fin;
  bit                m_a_fin;
  bit                m_pref_trans;   // trans wins the next tie
  bit                m_rvt;
  bit                m_rva;
  int                m_tc;
  int                m_ac;
  bit                e_gt;
  bit                e_ga;
  logic [OBS_W-1:0]  e_vec;

  function automatic logic [OBS_W-1:0] observed();
    return {trans_start, aggr_start, gnt_trans, gnt_aggr, mem_read_en,
            mem_addr, rvalid_trans, rvalid_aggr, busy, done};
  endfunction

  task automatic model_reset();
    m_phase      = P_IDLE;
    m_t_fin      = 1'b0;
    m_a_fin      = 1'b0;
    m_pref_trans = 1'b1;
    m_rvt        = 1'b0;
    m_rva        = 1'b0;
    m_tc         = 0;
    m_ac         = 0;
  endtask

  task automatic model_eval();
    bit                want_t;
    bit                want_a;
    bit                launching;
    logic [ADDR_W-1:0] a;
    want_t    = (m_phase == P_RUN) && (req_trans === 1'b1) && !m_t_fin;
    want_a    = (m_phase == P_RUN) && (req_aggr  === 1'b1) && !m_a_fin;
    e_gt      = want_t && (!want_a || m_pref_trans);
    e_ga      = want_a && (!want_t || !m_pref_trans);
    a         = e_gt ? addr_trans : (e_ga ? addr_aggr : {ADDR_W{1'b0}});
    launching = (m_phase == P_LAUNCH);
    e_vec = {launching, launching, e_gt, e_ga, e_gt | e_ga, a, m_rvt, m_rva,
             launching || (m_phase == P_RUN), m_phase == P_DONE};
  endtask

  task automatic model_clock();
    m_rvt = e_gt;
    m_rva = e_ga;
    if (e_gt)      m_pref_trans = 1'b0;
    else if (e_ga) m_pref_trans = 1'b1;
    case (m_phase)
      P_IDLE:   if (start) m_phase = P_LAUNCH;
      P_LAUNCH: begin
        m_t_fin = 1'b0;
        m_a_fin = 1'b0;
        m_tc    = 0;
        m_ac    = 0;
        m_phase = P_RUN;
      end
      P_RUN: begin
        if (!m_t_fin && m_tc < CYC_MAX) m_tc++;
        if (!m_a_fin && m_ac < CYC_MAX) m_ac++;
        if (trans_done) m_t_fin = 1'b1;
        if (aggr_done)  m_a_fin = 1'b1;
        if (m_t_fin && m_a_fin) m_phase = P_DONE;
      end
      default:  if (start) m_phase = P_LAUNCH;
    endcase
  endtask

  // Cross one rising edge with the model in step, return at the falling edge.
  task automatic advance();
    @(posedge clk);
    model_eval();
    model_clock();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    start      = 1'b0;
    trans_done = 1'b0;
    aggr_done  = 1'b0;
    req_trans  = 1'b0;
    req_aggr   = 1'b0;
    addr_trans = '0;
    addr_aggr  = '0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1; model_eval();
    n_tests++;
    if (observed() !== {OBS_W{1'b0}}) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", observed(), {OBS_W{1'b0}});
    end
    reset_n = 1'b1;
    start   = 1'b1;
    #1; model_eval();
    n_tests++;
    if (observed() !== e_vec) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %h expected %h", observed(), e_vec);
    end
    advance();
    start = 1'b0;
    #1; model_eval();
    n_tests++;
    if (observed() !== e_vec || trans_start !== 1'b1 || aggr_start !== 1'b1) begin
      n_fail++;
      $display("FAIL launch_pulse: got %h expected %h", observed(), e_vec);
    end
    advance();
    #1; model_eval();
    n_tests++;
    if (observed() !== e_vec || busy !== 1'b1 || trans_start !== 1'b0 ||
        gnt_trans !== 1'b0 || gnt_aggr !== 1'b0) begin
      n_fail++;
      $display("FAIL run_entry: got %h expected %h", observed(), e_vec);
    end
  endtask

  task automatic test_contention();
    for (int i = 0; i < 6; i++) begin
      req_trans  = 1'b1;
      req_aggr   = 1'b1;
      addr_trans = ADDR_W'($urandom);
      addr_aggr  = ADDR_W'($urandom);
      #1; model_eval();
      n_tests++;
      if (observed() !== e_vec) begin
        n_fail++;
        $display("FAIL contention_vec[%0d]: got %h expected %h", i, observed(), e_vec);
      end
      n_tests++;
      if (gnt_trans !== (i % 2 == 0) || gnt_aggr !== (i % 2 == 1) ||
          mem_addr !== ((i % 2 == 0) ? addr_trans : addr_aggr)) begin
        n_fail++;
        $display("FAIL contention_order[%0d]: got gt=%b ga=%b addr=%h", i,
                 gnt_trans, gnt_aggr, mem_addr);
      end
      advance();
    end
    req_trans = 1'b0;
    req_aggr  = 1'b0;
    #1; model_eval();
    n_tests++;
    if (observed() !== e_vec || rvalid_aggr !== 1'b1) begin
      n_fail++;
      $display("FAIL contention_tail: got %h expected %h", observed(), e_vec);
    end
    advance();
  endtask

  task automatic test_single();
    req_trans  = 1'b1;
    addr_trans = 7'h15;
    #1; model_eval();
    n_tests++;
    if (observed() !== e_vec || gnt_trans !== 1'b1 || mem_read_en !== 1'b1 ||
        mem_addr !== 7'h15) begin
      n_fail++;
      $display("FAIL single_grant: got %h expected %h", observed(), e_vec);
    end
    advance();
    req_trans = 1'b0;
    #1; model_eval();
    n_tests++;
    if (observed() !== e_vec || rvalid_trans !== 1'b1 || gnt_trans !== 1'b0) begin
      n_fail++;
      $display("FAIL single_rvalid: got %h expected %h", observed(), e_vec);
    end
    advance();
  endtask

  task automatic test_masking();
    trans_done = 1'b1;
    advance();
    trans_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_trans  = 1'b1;
      req_aggr   = 1'b1;
      addr_trans = ADDR_W'($urandom);
      addr_aggr  = ADDR_W'($urandom);
      #1; model_eval();
      n_tests++;
      if (observed() !== e_vec || gnt_trans !== 1'b0 || gnt_aggr !== 1'b1 ||
          mem_addr !== addr_aggr) begin
        n_fail++;
        $display("FAIL mask_trans[%0d]: got %h expected %h", i, observed(), e_vec);
      end
      advance();
    end
    aggr_done = 1'b1;
    advance();
    aggr_done = 1'b0;
    req_trans = 1'b0;
    req_aggr  = 1'b0;
    #1; model_eval();
    n_tests++;
    if (observed() !== e_vec || done !== 1'b1 || busy !== 1'b0 ||
        gnt_aggr !== 1'b0) begin
      n_fail++;
      $display("FAIL mask_done: got %h expected %h", observed(), e_vec);
    end
    advance();
  endtask

  task automatic test_simul_done_relaunch();
    start = 1'b1;
    advance();
    start = 1'b0;
    #1; model_eval();
    n_tests++;
    if (observed() !== e_vec || done !== 1'b0 || trans_start !== 1'b1) begin
      n_fail++;
      $display("FAIL relaunch: got %h expected %h", observed(), e_vec);
    end
    advance();
    trans_done = 1'b1;
    aggr_done  = 1'b1;
    #1; model_eval();
    n_tests++;
    if (observed() !== e_vec || busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_done_cycle: got %h expected %h", observed(), e_vec);
    end
    advance();
    trans_done = 1'b0;
    aggr_done  = 1'b0;
    start      = 1'b1;
    #1; model_eval();
    n_tests++;
    if (observed() !== e_vec || done !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_done_next: got %h expected %h", observed(), e_vec);
    end
    advance();
    start = 1'b0;
    #1; model_eval();
    n_tests++;
    if (observed() !== e_vec || done !== 1'b0 || aggr_start !== 1'b1) begin
      n_fail++;
      $display("FAIL relaunch_from_done: got %h expected %h", observed(), e_vec);
    end
    advance();
  endtask

  task automatic test_mid_reset();
    // Starts in RUN; a trans grant moves the priority toward aggregation.
    req_trans  = 1'b1;
    addr_trans = ADDR_W'($urandom);
    advance();
    #1; model_eval();
    n_tests++;
    if (observed() !== e_vec || gnt_trans !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_grant: got %h expected %h", observed(), e_vec);
    end
    reset_n = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if (observed() !== {OBS_W{1'b0}}) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected %h", observed(), {OBS_W{1'b0}});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n   = 1'b1;
    req_trans = 1'b0;
    start     = 1'b1;
    #1; model_eval();
    n_tests++;
    if (observed() !== e_vec) begin
      n_fail++;
      $display("FAIL idle_after_mid_reset: got %h expected %h", observed(), e_vec);
    end
    advance();
    start = 1'b0;
    advance();
    req_trans = 1'b1;
    req_aggr  = 1'b1;
    #1; model_eval();
    n_tests++;
    if (observed() !== e_vec || gnt_trans !== 1'b1 || gnt_aggr !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_after_reset: got %h expected %h", observed(), e_vec);
    end
    advance();
    req_trans = 1'b0;
    req_aggr  = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      start      = ($urandom_range(0, 5) == 0);
      req_trans  = $urandom_range(0, 1);
      req_aggr   = $urandom_range(0, 1);
      addr_trans = ADDR_W'($urandom);
      addr_aggr  = ADDR_W'($urandom);
      trans_done = ($urandom_range(0, 11) == 0);
      aggr_done  = ($urandom_range(0, 11) == 0);
      #1; model_eval();
      n_tests++;
      if (observed() !== e_vec) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h expected %h", i, observed(), e_vec);
      end
`ifdef GCN_SCHED_PERF_CNT_EN
      n_tests++;
      if (trans_cycles !== CYC_W'(m_tc) || aggr_cycles !== CYC_W'(m_ac)) begin
        n_fail++;
        $display("FAIL random_cycles[%0d]: got %0d/%0d expected %0d/%0d", i,
                 trans_cycles, aggr_cycles, m_tc, m_ac);
      end
`endif
      advance();
    end
    clear_inputs();
  endtask

`ifdef GCN_SCHED_PERF_CNT_EN
  task automatic test_perf();
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    start   = 1'b1;
    advance();
    start = 1'b0;
    advance();
    for (int c = 1; c <= 10; c++) begin
      trans_done = (c == 10);
      advance();
    end
    trans_done = 1'b0;
    repeat (5) advance();
    #1;
    n_tests++;
    if (trans_cycles !== 16'd10 || aggr_cycles !== CYC_W'(m_ac)) begin
      n_fail++;
      $display("FAIL perf_freeze: got %0d/%0d expected 10/%0d", trans_cycles,
               aggr_cycles, m_ac);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    clear_inputs();
    model_reset();
    test_reset();
    test_contention();
    test_single();
    test_masking();
    test_simul_done_relaunch();
    test_mid_reset();
    test_random();
`ifdef GCN_SCHED_PERF_CNT_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
